// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle scan controller.
// Vertices are packed {x, y, z}. Index 2 is x, index 1 is y and index 0 is z.
package raster_pkg;

    localparam int VX = 2;
    localparam int VY = 1;
    localparam int VZ = 0;

    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;

    typedef logic [2:0][8:0] vertex_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BBOX,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_t;

    function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        logic [8:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        logic [8:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tri_bbox.sv
// Screen-clamped bounding box of three vertices. This block is purely combinational and has zero latency.
// Only the maxima are clamped, so an off-screen minimum produces an empty box.
import raster_pkg::*;

module tri_bbox #(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic [8:0] x1_i,
    input  logic [8:0] y1_i,
    input  logic [8:0] x2_i,
    input  logic [8:0] y2_i,
    input  logic [8:0] x3_i,
    input  logic [8:0] y3_i,
    output logic [8:0] xmin_o,
    output logic [8:0] xmax_o,
    output logic [8:0] ymin_o,
    output logic [8:0] ymax_o,
    output logic       empty_o
);
    localparam logic [8:0] XLIM = 9'(SCREEN_W - 1);
    localparam logic [8:0] YLIM = 9'(SCREEN_H - 1);

    logic [8:0] xmax_raw;
    logic [8:0] ymax_raw;

    always_comb begin
        xmin_o   = min3(x1_i, x2_i, x3_i);
        ymin_o   = min3(y1_i, y2_i, y3_i);
        xmax_raw = max3(x1_i, x2_i, x3_i);
        ymax_raw = max3(y1_i, y2_i, y3_i);
        xmax_o   = (xmax_raw > XLIM) ? XLIM : xmax_raw;
        ymax_o   = (ymax_raw > YLIM) ? YLIM : ymax_raw;
        empty_o  = (xmin_o > xmax_o) || (ymin_o > ymax_o);
    end

endmodule

// File: rtl/tri_raster_ctrl.sv
// Walks a triangle's clamped bounding box in row-major order with one tester request outstanding at a time.
// Each pixel takes 4 cycles, or 5+ if it is inside. The EMIT state holds the fragment stable until frag_ready.
import raster_pkg::*;

module tri_raster_ctrl #(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  vertex_t    v1,
    input  vertex_t    v2,
    input  vertex_t    v3,
    input  logic       tri_valid,
    output logic       tri_ready,
    output vertex_t    tv1,
    output vertex_t    tv2,
    output vertex_t    tv3,
    output logic [8:0] tst_x,
    output logic [8:0] tst_y,
    output logic       tst_valid,
    input  logic       tst_in_tri,
    input  logic       tst_valid_out,
    output logic [8:0] frag_x,
    output logic [8:0] frag_y,
    output logic       frag_valid,
    input  logic       frag_ready,
    output logic       tri_done,
    output logic       busy
);
    state_t     state_q, state_d;
    vertex_t    tv1_q, tv1_d, tv2_q, tv2_d, tv3_q, tv3_d;
    logic [8:0] cx_q, cx_d, cy_q, cy_d;
    logic [8:0] xmin_q, xmin_d, xmax_q, xmax_d, ymax_q, ymax_d;
    logic [8:0] fx_q, fx_d, fy_q, fy_d;
    logic       advance;

    logic [8:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic       bb_empty;

    tri_bbox #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_bbox (
        .x1_i    (tv1_q[VX]),
        .y1_i    (tv1_q[VY]),
        .x2_i    (tv2_q[VX]),
        .y2_i    (tv2_q[VY]),
        .x3_i    (tv3_q[VX]),
        .y3_i    (tv3_q[VY]),
        .xmin_o  (bb_xmin),
        .xmax_o  (bb_xmax),
        .ymin_o  (bb_ymin),
        .ymax_o  (bb_ymax),
        .empty_o (bb_empty)
    );

    always_comb begin
        state_d = state_q;
        tv1_d   = tv1_q;
        tv2_d   = tv2_q;
        tv3_d   = tv3_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymax_d  = ymax_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        advance = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tri_valid) begin
                    tv1_d   = v1;
                    tv2_d   = v2;
                    tv3_d   = v3;
                    state_d = ST_BBOX;
                end
            end
            ST_BBOX: begin
                xmin_d = bb_xmin;
                xmax_d = bb_xmax;
                ymax_d = bb_ymax;
                if (bb_empty) begin
                    state_d = ST_DONE;
                end else begin
                    cx_d    = bb_xmin;
                    cy_d    = bb_ymin;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tst_valid_out) begin
                    if (tst_in_tri) begin
                        fx_d    = cx_q;
                        fy_d    = cy_q;
                        state_d = ST_EMIT;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_EMIT: advance = frag_ready;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // cx/cy never exceed the clamped maxima, so the 9-bit increments cannot wrap.
        if (advance) begin
            if (cx_q < xmax_q) begin
                cx_d    = cx_q + 9'd1;
                state_d = ST_ISSUE;
            end else if (cy_q < ymax_q) begin
                cx_d    = xmin_q;
                cy_d    = cy_q + 9'd1;
                state_d = ST_ISSUE;
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            tv1_q   <= '0;
            tv2_q   <= '0;
            tv3_q   <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
        end else begin
            state_q <= state_d;
            tv1_q   <= tv1_d;
            tv2_q   <= tv2_d;
            tv3_q   <= tv3_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymax_q  <= ymax_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
        end
    end

    assign tri_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign tst_valid  = (state_q == ST_ISSUE);
    assign frag_valid = (state_q == ST_EMIT);
    assign tri_done   = (state_q == ST_DONE);
    assign tst_x      = cx_q;
    assign tst_y      = cy_q;
    assign frag_x     = fx_q;
    assign frag_y     = fy_q;
    assign tv1        = tv1_q;
    assign tv2        = tv2_q;
    assign tv3        = tv3_q;

endmodule
